// File: rtl/dyn_node_refresh_ctrl.sv
// Gate/data driver for an nmos-gated dynamic storage node: write pulses, periodic
// refresh before the charge decays, and a cycle-level model of the node contents.
module dyn_node_refresh_ctrl #(
  parameter int DECAY          = 50,
  parameter int REFRESH_MARGIN = 10,
  parameter int GATE_PULSE     = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_req_i,
  input  logic             wr_data_i,
  input  logic             refresh_en_i,
  output logic             wr_ack_o,
  output logic             gate_o,
  output logic             data_drv_o,
  output logic             node_val_o,
  output logic             node_valid_o,
  output logic             busy_o,
  output logic             decay_err_o,
  output logic [CNT_W-1:0] refresh_cnt_o
);

  localparam int AGE_W = $clog2(DECAY + 1);
  localparam int PLS_W = (GATE_PULSE > 1) ? $clog2(GATE_PULSE) : 1;
  localparam logic [AGE_W-1:0] TRIG_AGE = AGE_W'(DECAY - REFRESH_MARGIN);
  localparam logic [AGE_W-1:0] LAST_AGE = AGE_W'(DECAY - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(GATE_PULSE - 1);

  typedef enum logic [1:0] {S_EMPTY, S_WRITE, S_HOLD, S_REFRESH} state_e;

  state_e           state_q, state_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [PLS_W-1:0] pls_q, pls_d;
  logic             drv_q, drv_d;
  logic             val_q, val_d;
  logic             vld_q, vld_d;
  logic             ack_q, ack_d;
  logic             derr_q, derr_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             accept;

  assign accept = wr_req_i && (state_q == S_EMPTY || state_q == S_HOLD);

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    pls_d   = pls_q;
    drv_d   = drv_q;
    val_d   = val_q;
    vld_d   = vld_q;
    ack_d   = 1'b0;
    derr_d  = 1'b0;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_EMPTY, S_HOLD: begin
        // A write always beats refresh: it recharges the node anyway.
        if (accept) begin
          state_d = S_WRITE;
          pls_d   = '0;
          age_d   = '0;
          drv_d   = wr_data_i;
          val_d   = wr_data_i;
          vld_d   = 1'b1;
          ack_d   = 1'b1;
        end else if (state_q == S_HOLD) begin
          if (age_q == TRIG_AGE && refresh_en_i) begin
            state_d = S_REFRESH;
            pls_d   = '0;
            drv_d   = val_q;
          end else if (age_q == LAST_AGE) begin
            state_d = S_EMPTY;
            vld_d   = 1'b0;
            derr_d  = 1'b1;
            age_d   = '0;
          end else begin
            age_d = age_q + AGE_W'(1);
          end
        end
      end
      S_WRITE, S_REFRESH: begin
        if (pls_q == PLS_LAST) begin
          state_d = S_HOLD;
          pls_d   = '0;
          age_d   = '0;
          if (state_q == S_REFRESH) rcnt_d = rcnt_q + CNT_W'(1);
        end else begin
          pls_d = pls_q + PLS_W'(1);
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      age_q   <= '0;
      pls_q   <= '0;
      drv_q   <= 1'b0;
      val_q   <= 1'b0;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
      derr_q  <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      pls_q   <= pls_d;
      drv_q   <= drv_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      derr_q  <= derr_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign busy_o        = (state_q == S_WRITE) || (state_q == S_REFRESH);
  assign gate_o        = busy_o;
  assign wr_ack_o      = ack_q;
  assign data_drv_o    = drv_q;
  assign node_val_o    = val_q;
  assign node_valid_o  = vld_q;
  assign decay_err_o   = derr_q;
  assign refresh_cnt_o = rcnt_q;

endmodule

// File: tb/tb_dyn_node_refresh_ctrl.sv
// Directed test-plan scenarios plus random traffic, checked every cycle against
// a behavioural node model; a second instance with a 2-bit counter checks wrap.
module tb_dyn_node_refresh_ctrl;
  localparam int DECAY = 50, MARGIN = 10, GP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, wr_req, wr_data, refresh_en;
  logic wr_ack, gate, data_drv, node_val, node_valid, busy, decay_err;
  logic [7:0] refresh_cnt;
  logic wr_ack2, gate2, data_drv2, node_val2, node_valid2, busy2, decay_err2;
  logic [1:0] refresh_cnt2;

  dyn_node_refresh_ctrl #(.DECAY(DECAY), .REFRESH_MARGIN(MARGIN), .GATE_PULSE(GP), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_data_i(wr_data), .refresh_en_i(refresh_en),
    .wr_ack_o(wr_ack), .gate_o(gate), .data_drv_o(data_drv), .node_val_o(node_val),
    .node_valid_o(node_valid), .busy_o(busy), .decay_err_o(decay_err), .refresh_cnt_o(refresh_cnt));

  dyn_node_refresh_ctrl #(.DECAY(DECAY), .REFRESH_MARGIN(MARGIN), .GATE_PULSE(GP), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .wr_req_i(wr_req), .wr_data_i(wr_data), .refresh_en_i(refresh_en),
    .wr_ack_o(wr_ack2), .gate_o(gate2), .data_drv_o(data_drv2), .node_val_o(node_val2),
    .node_valid_o(node_valid2), .busy_o(busy2), .decay_err_o(decay_err2), .refresh_cnt_o(refresh_cnt2));

  int n_vec = 0, n_err = 0, t = 0;

  // Model: remaining gate cycles, HOLD age, charge validity, refresh total.
  int m_pulse, m_age, m_cnt;
  bit m_ref, m_drv, m_val, m_vld, m_ack, m_derr;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit q, input bit d, input bit e);
    m_ack = 0; m_derr = 0;
    if (r) begin
      m_pulse = 0; m_age = 0; m_cnt = 0; m_ref = 0;
      m_drv = 0; m_val = 0; m_vld = 0;
    end else if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) begin
        if (m_ref) m_cnt++;
        m_age = 0;
      end
    end else if (q) begin
      m_pulse = GP; m_ref = 0; m_drv = d; m_val = d; m_vld = 1; m_age = 0; m_ack = 1;
    end else if (m_vld) begin
      if (m_age == DECAY - MARGIN && e) begin
        m_pulse = GP; m_ref = 1; m_drv = m_val;
      end else if (m_age == DECAY - 1) begin
        m_vld = 0; m_derr = 1;
      end else m_age++;
    end
  endtask

  task automatic cyc(input bit r, input bit q, input bit d, input bit e);
    @(negedge clk);
    rst = r; wr_req = q; wr_data = d; refresh_en = e;
    @(posedge clk);
    model_step(r, q, d, e);
    #1;
    t++;
    chk("gate", gate, int'(m_pulse > 0));
    chk("busy", busy, int'(m_pulse > 0));
    chk("data_drv", data_drv, m_drv);
    chk("node_val", node_val, m_val);
    chk("node_valid", node_valid, m_vld);
    chk("wr_ack", wr_ack, m_ack);
    chk("decay_err", decay_err, m_derr);
    chk("refresh_cnt", refresh_cnt, m_cnt % 256);
    chk("refresh_cnt_w2", refresh_cnt2, m_cnt % 4);
    chk("gate_w2", gate2, int'(m_pulse > 0));
  endtask

  initial begin
    bit pend, pdata, ren, r;
    rst = 1; wr_req = 0; wr_data = 0; refresh_en = 0;

    // Reset, write 1, then refresh for 500 cycles
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    chk("rst_gate", gate, 0); chk("rst_valid", node_valid, 0); chk("rst_cnt", refresh_cnt, 0);
    t = 0;
    cyc(0, 1, 1, 0);
    chk("w_ack1", wr_ack, 1); chk("w_gate1", gate, 1); chk("w_val1", node_val, 1);
    while (t < 500) begin
      cyc(0, 0, 0, 1);
      if (t == 2)  chk("w_gate2", gate, 1);
      if (t == 3)  chk("hold_gate3", gate, 0);
      if (t == 43) chk("pre_ref_gate", gate, 0);
      if (t == 44) chk("ref_gate44", gate, 1);
      if (t == 45) chk("ref_gate45", gate, 1);
      if (t == 46) begin chk("ref_done_gate", gate, 0); chk("ref_cnt46", refresh_cnt, 1); end
    end
    chk("ref_cnt500", refresh_cnt, 11);
    chk("ref_cnt500_w2", refresh_cnt2, 3);
    chk("valid500", node_valid, 1);

    // Decay without refresh
    cyc(1, 0, 0, 0); t = 0;
    cyc(0, 1, 1, 0);
    while (t < 52) cyc(0, 0, 0, 0);
    chk("decay_valid52", node_valid, 1);
    cyc(0, 0, 0, 0);
    chk("decay_valid53", node_valid, 0); chk("decay_err53", decay_err, 1);
    chk("decay_val53", node_val, 1); chk("decay_busy53", busy, 0);
    cyc(0, 0, 0, 0);
    chk("decay_err54", decay_err, 0);

    // Write coinciding with refresh trigger, then write during refresh
    cyc(1, 0, 0, 0); t = 0;
    cyc(0, 1, 1, 1);
    while (t < 43) cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    chk("coll_ack", wr_ack, 1); chk("coll_gate", gate, 1); chk("coll_drv", data_drv, 0);
    chk("coll_val", node_val, 0); chk("coll_cnt", refresh_cnt, 0);
    cyc(0, 0, 0, 1);
    while (t < 87) cyc(0, 0, 0, 1);
    chk("ref2_gate87", gate, 1);
    while (t < 90) begin
      cyc(0, 1, 1, 1);
      if (t < 90) chk("blocked_ack", wr_ack, 0);
    end
    chk("late_ack90", wr_ack, 1); chk("late_cnt90", refresh_cnt, 1);
    cyc(0, 0, 0, 1);

    // Reset in the middle of a write pulse
    cyc(1, 0, 0, 1); t = 0;
    cyc(0, 1, 1, 1);
    cyc(1, 0, 0, 1);
    chk("midrst_gate", gate, 0); chk("midrst_valid", node_valid, 0);
    chk("midrst_ack", wr_ack, 0); chk("midrst_busy", busy, 0);

    // Random traffic
    cyc(0, 0, 0, 0);
    pend = 0; pdata = 0; ren = 1;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) ren = ~ren;
      if (!pend && $urandom_range(0, 99) < 2) begin
        pend = 1; pdata = 1'($urandom_range(0, 1));
      end
      cyc(r, pend, pdata, ren);
      if (m_ack || r) pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dyn_node_refresh_ctrl.md
Name: dyn_node_refresh_ctrl

Overview:
Clocked controller that drives the gate and data inputs of an nmos-gated charge-storage node. The node holds charge only for a bounded decay time. The block accepts write requests, pulses the gate to charge the node, and tracks the age of the stored charge. Before the decay limit it re-pulses the gate with the stored value (refresh). It also keeps a cycle-level model of the node's value and validity for downstream consumers.

Parameters:
DECAY, 50, cycles a charged node stays valid with gate low (≥4)
REFRESH_MARGIN, 10, refresh is launched when age reaches DECAY-REFRESH_MARGIN (1 ≤ margin < DECAY-GATE_PULSE)
GATE_PULSE, 2, cycles gate is held high per write or refresh (≥1)
CNT_W, 8, width of refresh counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_req  in  1  request to write wr_data into node; hold until wr_ack
wr_data  in  1  value to store
refresh_en  in  1  1 = automatic refresh enabled
wr_ack  out  1  one-cycle pulse: request accepted
gate  out  1  nmos gate drive
data_drv  out  1  nmos data drive
node_val  out  1  modelled stored value
node_valid  out  1  stored charge within decay window
busy  out  1  high in WRITE or REFRESH
decay_err  out  1  one-cycle pulse when charge expires unrefreshed
refresh_cnt  out  CNT_W  completed refreshes, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): state EMPTY, all outputs 0, age=0, pulse counter=0. Reset overrides any state, including mid-pulse. gate drops the cycle after rst is sampled.
- States: EMPTY, WRITE, HOLD, REFRESH.
- Accepting a write:
  - A write is accepted in EMPTY or HOLD when wr_req=1.
  - Next cycle: state=WRITE, wr_ack=1 for that cycle only, data_drv=wr_data (latched), gate=1, node_val=wr_data, node_valid=1, age=0.
  - In WRITE or REFRESH, wr_req is not accepted. The requester keeps wr_req high, and it is accepted on the first HOLD cycle.
- WRITE and REFRESH pulses:
  - gate=1 for exactly GATE_PULSE cycles, then state goes to HOLD with gate=0.
  - data_drv keeps the driven value through HOLD; it changes only at the start of the next pulse.
- HOLD:
  - age increments by 1 each cycle, starting at 0 on the first HOLD cycle.
  - Priority at each edge: rst > wr_req > refresh trigger > decay.
  - Refresh trigger: age==DECAY-REFRESH_MARGIN and refresh_en=1. Next state is REFRESH: gate=1, data_drv=node_val.
  - Refresh completion: on the last REFRESH pulse cycle, refresh_cnt increments (wrapping) and age clears.
  - If wr_req and the refresh trigger coincide, the write wins. No refresh is counted, because the write recharges the node.
- Decay:
  - If age==DECAY-1 in HOLD with no write or refresh taken, next cycle state=EMPTY, node_valid=0, decay_err=1 for one cycle.
  - node_val keeps its last value; consumers must qualify it with node_valid.
  - So a node is valid for exactly DECAY HOLD cycles when not refreshed.
- refresh_en toggling:
  - Clearing refresh_en mid-REFRESH does not abort the pulse.
  - Setting refresh_en after the trigger age has passed gives no refresh; decay proceeds.
- busy = (state==WRITE || state==REFRESH).
- age counter width is clog2(DECAY+1). It never exceeds DECAY-1.

Test Plan:
- Reset, then wr_req=1, wr_data=1 at cycle 0 → wr_ack, gate, node_val=1, node_valid=1 at cycle 1; gate high cycles 1–2; HOLD from cycle 3; gate=0.
- refresh_en=1 after the above → gate rises at cycle 44 (age 40 at cycle 43), high 44–45; refresh_cnt=1 at cycle 46; node_valid stays 1 for 500 cycles and refresh_cnt reaches 11.
- refresh_en=0, write 1 at cycle 0 → node_valid=1 through cycle 52; cycle 53: node_valid=0, decay_err=1 single pulse, state EMPTY, node_val still 1.
- refresh_en=1, wr_req=1 with wr_data=0 asserted on the trigger cycle (cycle 43) → write taken: gate 44–45 with data_drv=0, node_val=0, refresh_cnt unchanged; wr_req raised during a REFRESH pulse → wr_ack on the first HOLD cycle after the pulse.
- rst asserted during WRITE cycle 1 → cycle 2: gate=0, node_valid=0, wr_ack=0, refresh_cnt=0, state EMPTY.
- CNT_W=2: run 5 refreshes → refresh_cnt sequence 1,2,3,0,1.
